// File: rtl/avg_filter_3x3.sv
// 3x3 mean filter stage: row sums -> total -> reciprocal multiply -> round/saturate, 4 clk latency.
// Define AVG_FILTER_EDGE_NORM_EN to average edge/corner windows over in-image pixels only.
module avg_filter_3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              matrix_img_vsync,
    input  logic              matrix_img_hsync,
    input  logic              matrix_img_valid,
    input  logic              matrix_top_edge_flag,
    input  logic              matrix_bottom_edge_flag,
    input  logic              matrix_left_edge_flag,
    input  logic              matrix_right_edge_flag,
    input  logic [DATA_W-1:0] matrix_p11,
    input  logic [DATA_W-1:0] matrix_p12,
    input  logic [DATA_W-1:0] matrix_p13,
    input  logic [DATA_W-1:0] matrix_p21,
    input  logic [DATA_W-1:0] matrix_p22,
    input  logic [DATA_W-1:0] matrix_p23,
    input  logic [DATA_W-1:0] matrix_p31,
    input  logic [DATA_W-1:0] matrix_p32,
    input  logic [DATA_W-1:0] matrix_p33,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_data
);

    localparam int unsigned ROW_W   = DATA_W + 2;
    localparam int unsigned SUM_W   = DATA_W + 4;
    localparam int unsigned RECIP_W = FRAC_W + 1;
    localparam int unsigned PROD_W  = DATA_W + 4 + FRAC_W + 1;
    localparam int unsigned ONE     = 1 << FRAC_W;

    localparam logic [RECIP_W-1:0] RECIP_9 = RECIP_W'((ONE + 4) / 9);
    localparam logic [PROD_W-1:0]  HALF    = PROD_W'(1) << (FRAC_W - 1);
    localparam logic [PROD_W-1:0]  PIX_MAX = PROD_W'({DATA_W{1'b1}});

    // S1: edge masking and row sums
    logic              keep_r1, keep_r3, keep_c1, keep_c3;
    logic [DATA_W-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic [ROW_W-1:0]  row1_c, row2_c, row3_c;

    always_comb begin
`ifdef AVG_FILTER_EDGE_NORM_EN
        keep_r1 = ~matrix_top_edge_flag;
        keep_r3 = ~matrix_bottom_edge_flag;
        keep_c1 = ~matrix_left_edge_flag;
        keep_c3 = ~matrix_right_edge_flag;
`else
        keep_r1 = 1'b1;
        keep_r3 = 1'b1;
        keep_c1 = 1'b1;
        keep_c3 = 1'b1;
`endif
        m11 = (keep_r1 && keep_c1) ? matrix_p11 : '0;
        m12 = keep_r1              ? matrix_p12 : '0;
        m13 = (keep_r1 && keep_c3) ? matrix_p13 : '0;
        m21 = keep_c1              ? matrix_p21 : '0;
        m22 = matrix_p22;
        m23 = keep_c3              ? matrix_p23 : '0;
        m31 = (keep_r3 && keep_c1) ? matrix_p31 : '0;
        m32 = keep_r3              ? matrix_p32 : '0;
        m33 = (keep_r3 && keep_c3) ? matrix_p33 : '0;
        row1_c = ROW_W'(m11) + ROW_W'(m12) + ROW_W'(m13);
        row2_c = ROW_W'(m21) + ROW_W'(m22) + ROW_W'(m23);
        row3_c = ROW_W'(m31) + ROW_W'(m32) + ROW_W'(m33);
    end

    logic [ROW_W-1:0]  s1_row1, s1_row2, s1_row3;
    logic [2:0]        s1_sync, s2_sync, s3_sync;
    logic [SUM_W-1:0]  s2_sum;
    logic [PROD_W-1:0] s3_prod;

`ifdef AVG_FILTER_EDGE_NORM_EN
    logic [1:0]         rows_c, cols_c;
    logic [1:0]         s1_rows, s1_cols;
    logic [3:0]         s2_n;
    logic [RECIP_W-1:0] recip_c;

    always_comb begin
        rows_c = 2'd3 - 2'(matrix_top_edge_flag) - 2'(matrix_bottom_edge_flag);
        cols_c = 2'd3 - 2'(matrix_left_edge_flag) - 2'(matrix_right_edge_flag);
    end

    // Rounded 2^FRAC_W / n; unreachable divisors fall back to the 3x3 value
    always_comb begin
        recip_c = RECIP_9;
        case (s2_n)
            4'd1:    recip_c = RECIP_W'(ONE);
            4'd2:    recip_c = RECIP_W'((ONE + 1) / 2);
            4'd3:    recip_c = RECIP_W'((ONE + 1) / 3);
            4'd4:    recip_c = RECIP_W'((ONE + 2) / 4);
            4'd6:    recip_c = RECIP_W'((ONE + 3) / 6);
            default: recip_c = RECIP_9;
        endcase
    end
`else
    logic              any_edge_c;
    logic              s1_byp, s2_byp, s3_byp;
    logic [DATA_W-1:0] s1_p22, s2_p22, s3_p22;
    logic [RECIP_W-1:0] recip_c;

    always_comb begin
        any_edge_c = matrix_top_edge_flag | matrix_bottom_edge_flag |
                     matrix_left_edge_flag | matrix_right_edge_flag;
        recip_c    = RECIP_9;
    end
`endif

    // S4 rounding, saturation and valid gating
    logic [PROD_W-1:0] rounded_c, scaled_c;
    logic [DATA_W-1:0] sat_c, data_c;

    always_comb begin
        rounded_c = s3_prod + HALF;
        scaled_c  = rounded_c >> FRAC_W;
        sat_c     = (scaled_c > PIX_MAX) ? {DATA_W{1'b1}} : DATA_W'(scaled_c);
`ifdef AVG_FILTER_EDGE_NORM_EN
        data_c    = s3_sync[0] ? sat_c : '0;
`else
        data_c    = s3_sync[0] ? (s3_byp ? s3_p22 : sat_c) : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_row1        <= '0;
            s1_row2        <= '0;
            s1_row3        <= '0;
            s1_sync        <= '0;
            s2_sync        <= '0;
            s3_sync        <= '0;
            s2_sum         <= '0;
            s3_prod        <= '0;
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_data  <= '0;
`ifdef AVG_FILTER_EDGE_NORM_EN
            s1_rows        <= '0;
            s1_cols        <= '0;
            s2_n           <= '0;
`else
            s1_byp         <= 1'b0;
            s2_byp         <= 1'b0;
            s3_byp         <= 1'b0;
            s1_p22         <= '0;
            s2_p22         <= '0;
            s3_p22         <= '0;
`endif
        end else begin
            s1_row1        <= row1_c;
            s1_row2        <= row2_c;
            s1_row3        <= row3_c;
            s1_sync        <= {matrix_img_vsync, matrix_img_hsync, matrix_img_valid};
            s2_sync        <= s1_sync;
            s3_sync        <= s2_sync;
            s2_sum         <= SUM_W'(s1_row1) + SUM_W'(s1_row2) + SUM_W'(s1_row3);
            s3_prod        <= PROD_W'(s2_sum) * PROD_W'(recip_c);
            post_img_vsync <= s3_sync[2];
            post_img_hsync <= s3_sync[1];
            post_img_valid <= s3_sync[0];
            post_img_data  <= data_c;
`ifdef AVG_FILTER_EDGE_NORM_EN
            s1_rows        <= rows_c;
            s1_cols        <= cols_c;
            s2_n           <= 4'(s1_rows) * 4'(s1_cols);
`else
            s1_byp         <= any_edge_c;
            s2_byp         <= s1_byp;
            s3_byp         <= s2_byp;
            s1_p22         <= matrix_p22;
            s2_p22         <= s1_p22;
            s3_p22         <= s2_p22;
`endif
        end
    end

endmodule
